rpn_evaluator: RTL

- Postfix (RPN) expression evaluator directly downstream of the shunting-yard parser.
- Drains the parser's output queue one token per cycle via the queue's read-enable, evaluates on an internal operand stack, and presents a 32-bit result with a done pulse and an error code.
- Token encoding matches the parser: ADD=0x8000000A, SUB=0x8000000B, MUL=0x8000000C, DIV=0x8000000D, EQU=0x8000000E, CLR=0x8000000F. Every other 32-bit value is a number.

---
 rtl/rpn_pkg.sv | 55 +++++
 rtl/rpn_divider.sv | 73 +++++++
 rtl/rpn_evaluator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluator: token codes, error codes, FSM states
// and a token classifier used by the evaluator's decode stage.
package rpn_pkg;

  localparam logic [31:0] TOK_ADD = 32'h8000_000A;
  localparam logic [31:0] TOK_SUB = 32'h8000_000B;
  localparam logic [31:0] TOK_MUL = 32'h8000_000C;
  localparam logic [31:0] TOK_DIV = 32'h8000_000D;
  localparam logic [31:0] TOK_EQU = 32'h8000_000E;
  localparam logic [31:0] TOK_CLR = 32'h8000_000F;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_UNDERFLOW   = 3'd1,
    ERR_OVERFLOW    = 3'd2,
    ERR_DIV_ZERO    = 3'd3,
    ERR_BAD_END     = 3'd4,
    ERR_UNEXP_CLR   = 3'd5,
    ERR_TOKEN_LIMIT = 3'd6
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DIV_WAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [2:0] {
    TK_NUM,
    TK_ADD,
    TK_SUB,
    TK_MUL,
    TK_DIV,
    TK_EQU,
    TK_CLR
  } tok_e;

  // Anything that is not one of the six operator codes is an operand.
  function automatic tok_e classify(input logic [31:0] tok);
    tok_e kind;
    case (tok)
      TOK_ADD: kind = TK_ADD;
      TOK_SUB: kind = TK_SUB;
      TOK_MUL: kind = TK_MUL;
      TOK_DIV: kind = TK_DIV;
      TOK_EQU: kind = TK_EQU;
      TOK_CLR: kind = TK_CLR;
      default: kind = TK_NUM;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/rpn_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved in the start cycle so done pulses exactly DATA_W cycles after start.
module rpn_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  logic [DATA_W-1:0] w_src_rem;
  logic [DATA_W-1:0] w_src_quo;
  logic [DATA_W-1:0] w_src_dvs;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_nxt_rem;
  logic [DATA_W-1:0] w_nxt_quo;

  // One restoring step; on start it operates on the fresh operands directly.
  always_comb begin
    w_src_rem = start ? '0       : r_rem;
    w_src_quo = start ? dividend : r_quo;
    w_src_dvs = start ? divisor  : r_dvs;
    w_trial   = {w_src_rem, w_src_quo[DATA_W-1]};
    if (w_trial >= {1'b0, w_src_dvs}) begin
      w_nxt_rem = DATA_W'(w_trial - {1'b0, w_src_dvs});
      w_nxt_quo = {w_src_quo[DATA_W-2:0], 1'b1};
    end else begin
      w_nxt_rem = w_trial[DATA_W-1:0];
      w_nxt_quo = {w_src_quo[DATA_W-2:0], 1'b0};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem <= w_nxt_rem;
        r_quo <= w_nxt_quo;
        r_dvs <= divisor;
        r_cnt <= CNT_W'(DATA_W - 1);
      end else if (r_cnt != '0) begin
        r_rem <= w_nxt_rem;
        r_quo <= w_nxt_quo;
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
      end
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix evaluator draining the shunting-yard parser's output queue one token
// per FETCH cycle onto a register operand stack; DIV is handed to rpn_divider.
module rpn_evaluator
  import rpn_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 16,
  parameter int MAX_TOKENS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_token,
  output logic              rd_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error,
  output logic [2:0]        err_code
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(MAX_TOKENS + 1);

  state_e            r_state;
  state_e            w_next;
  logic [SP_W-1:0]   r_sp;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_stack [STACK_DEPTH];
  logic [DATA_W-1:0] r_result;
  logic              r_error;
  err_e              r_err_code;

  tok_e              w_kind;
  logic              w_has2;
  logic              w_at_limit;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_a_idx;
  logic [IDX_W-1:0]  w_b_idx;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;

  logic              w_push;
  logic              w_alu_wr;
  logic              w_div_start;
  logic              w_div_wr;
  logic              w_sp_dec;
  logic              w_res_load;
  logic              w_err_set;
  err_e              w_err_val;

  logic [DATA_W-1:0] w_quotient;
  logic              w_div_done;

  assign w_kind     = classify(32'(in_token));
  assign w_has2     = (r_sp >= SP_W'(2));
  assign w_at_limit = (r_count == CNT_W'(MAX_TOKENS - 1));

  // Operand addresses are only meaningful with two entries on the stack.
  assign w_top_idx = IDX_W'(r_sp);
  assign w_a_idx   = w_has2 ? IDX_W'(r_sp - SP_W'(2)) : '0;
  assign w_b_idx   = w_has2 ? IDX_W'(r_sp - SP_W'(1)) : '0;
  assign w_a       = r_stack[w_a_idx];
  assign w_b       = r_stack[w_b_idx];

  always_comb begin
    w_alu = '0;
    case (w_kind)
      TK_ADD:  w_alu = w_a + w_b;
      TK_SUB:  w_alu = w_a - w_b;
      TK_MUL:  w_alu = w_a * w_b;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_alu_wr    = 1'b0;
    w_div_start = 1'b0;
    w_div_wr    = 1'b0;
    w_sp_dec    = 1'b0;
    w_res_load  = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = ERR_NONE;

    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end

      ST_FETCH: begin
        case (w_kind)
          TK_NUM: begin
            if (r_sp == SP_W'(STACK_DEPTH)) begin
              w_err_set = 1'b1;
              w_err_val = ERR_OVERFLOW;
            end else if (w_at_limit) begin
              w_err_set = 1'b1;
              w_err_val = ERR_TOKEN_LIMIT;
            end else begin
              w_push = 1'b1;
            end
          end
          TK_ADD, TK_SUB, TK_MUL: begin
            if (!w_has2) begin
              w_err_set = 1'b1;
              w_err_val = ERR_UNDERFLOW;
            end else if (w_at_limit) begin
              w_err_set = 1'b1;
              w_err_val = ERR_TOKEN_LIMIT;
            end else begin
              w_alu_wr = 1'b1;
              w_sp_dec = 1'b1;
            end
          end
          TK_DIV: begin
            if (!w_has2) begin
              w_err_set = 1'b1;
              w_err_val = ERR_UNDERFLOW;
            end else if (w_b == '0) begin
              w_err_set = 1'b1;
              w_err_val = ERR_DIV_ZERO;
            end else if (w_at_limit) begin
              w_err_set = 1'b1;
              w_err_val = ERR_TOKEN_LIMIT;
            end else begin
              w_div_start = 1'b1;
              w_next      = ST_DIV_WAIT;
            end
          end
          TK_EQU: begin
            if (r_sp == SP_W'(1)) begin
              w_res_load = 1'b1;
              w_next     = ST_DONE;
            end else begin
              w_err_set = 1'b1;
              w_err_val = ERR_BAD_END;
            end
          end
          default: begin
            w_err_set = 1'b1;
            w_err_val = ERR_UNEXP_CLR;
          end
        endcase
        if (w_err_set) w_next = ST_ERR;
      end

      ST_DIV_WAIT: begin
        if (w_div_done) begin
          w_div_wr = 1'b1;
          w_sp_dec = 1'b1;
          w_next   = ST_FETCH;
        end
      end

      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Error flags are written on the transition into ERR so they are already
  // valid in the cycle that carries the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp       <= '0;
      r_count    <= '0;
      r_result   <= '0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_sp       <= '0;
        r_count    <= '0;
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (r_state == ST_FETCH) r_count <= r_count + CNT_W'(1);
      if (w_push)              r_sp    <= r_sp + SP_W'(1);
      if (w_sp_dec)            r_sp    <= r_sp - SP_W'(1);
      if (w_res_load)          r_result <= r_stack[0];
      if (w_err_set) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_val;
      end
    end
  end

  // NOTE: the operand stack is storage, not control state: it is never read
  // above sp, so it carries no reset and is simply overwritten by pushes.
  always_ff @(posedge clk) begin
    if (w_push)   r_stack[w_top_idx] <= in_token;
    if (w_alu_wr) r_stack[w_a_idx]   <= w_alu;
    if (w_div_wr) r_stack[w_a_idx]   <= w_quotient;
  end

  rpn_divider #(
    .DATA_W(DATA_W)
  ) u_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_div_start),
    .dividend(w_a),
    .divisor (w_b),
    .quotient(w_quotient),
    .done    (w_div_done)
  );

  assign rd_en    = (r_state == ST_FETCH);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE) || (r_state == ST_ERR);
  assign result   = r_result;
  assign error    = r_error;
  assign err_code = r_err_code;

endmodule
